// File: rtl/npu_pkg.sv
// Shared definitions for the data chunk path.
// Holds the default chunk geometry, the beat count per chunk with its counter
// width, and the state encoding of the read-side sequencer in data_chunk_loader.
`ifndef MEM_SIZE
`define MEM_SIZE 64
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 16
`endif

package npu_pkg;

    localparam int unsigned MEM_SIZE_DEF = `MEM_SIZE;
    localparam int unsigned BUS_SIZE_DEF = `BUS_SIZE;

    // Beats per chunk for the default geometry, and the width of the beat counter.
    localparam int unsigned WR_CYC_NUM = MEM_SIZE_DEF / BUS_SIZE_DEF;
    localparam int unsigned WR_CNT_W   = $clog2(WR_CYC_NUM);

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_ACTIVE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/data_chunk_loader.sv
// Ping-pong write controller in front of the two data chunk buffers.
// Groups WR_CYC_NUM accepted beats into one chunk write, alternating between
// buffer 0 and buffer 1, then hands each loaded buffer to the read side.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   in_valid_i / in_ready_o            source beat handshake
//   in_sparsemap_i, in_nonzero_data_i  beat payload
//   wr_sparsemap_o, wr_nonzero_data_o  registered payload towards the buffers
//   wr_valid_o, wr_count_o, wr_sel_o   write strobe, beat index, target buffer
//   rd_sel_o                           buffer the read side uses
//   chunk_start_o                      one-cycle pulse when a read chunk begins
//   chunk_ready_o                      read buffer loaded and active
//   chunk_done_i                       consumer finished the active chunk
`ifndef MEM_SIZE
`define MEM_SIZE 64
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 16
`endif

module data_chunk_loader
    import npu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = `MEM_SIZE,
    parameter int unsigned BUS_SIZE = `BUS_SIZE
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         in_valid_i,
    output logic                                         in_ready_o,
    input  logic [BUS_SIZE-1:0]                          in_sparsemap_i,
    input  logic [BUS_SIZE-1:0][7:0]                     in_nonzero_data_i,
    output logic [BUS_SIZE-1:0]                          wr_sparsemap_o,
    output logic [BUS_SIZE-1:0][7:0]                     wr_nonzero_data_o,
    output logic                                         wr_valid_o,
    output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]         wr_count_o,
    output logic                                         wr_sel_o,
    output logic                                         rd_sel_o,
    output logic                                         chunk_start_o,
    output logic                                         chunk_ready_o,
    input  logic                                         chunk_done_i
);

    localparam int unsigned WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
    localparam int unsigned CNT_W      = $clog2(WR_CYC_NUM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WR_CYC_NUM - 1);

    // Write side
    logic                     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
    logic [1:0]               buf_full_q, buf_full_d;
    // Read side
    logic [1:0]               buf_rdy_q, buf_rdy_d;
    logic                     rd_ptr_q, rd_ptr_d;
    rd_state_e                state_q, state_d;
    // Registered outputs
    logic [BUS_SIZE-1:0]      wr_sm_q, wr_sm_d;
    logic [BUS_SIZE-1:0][7:0] wr_data_q, wr_data_d;
    logic                     wr_valid_q, wr_valid_d;
    logic [CNT_W-1:0]         wr_count_q, wr_count_d;
    logic                     wr_sel_q, wr_sel_d;
    logic                     chunk_start_q, chunk_start_d;

    logic accept;
    logic last_beat;

    assign in_ready_o = !rst_i && !buf_full_q[wr_ptr_q];
    assign accept     = in_valid_i && in_ready_o;
    assign last_beat  = (wr_cnt_q == LAST_CNT);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        wr_cnt_d      = wr_cnt_q;
        buf_full_d    = buf_full_q;
        buf_rdy_d     = buf_rdy_q;
        rd_ptr_d      = rd_ptr_q;
        state_d       = state_q;
        wr_sm_d       = wr_sm_q;
        wr_data_d     = wr_data_q;
        wr_valid_d    = 1'b0;
        wr_count_d    = wr_count_q;
        wr_sel_d      = wr_sel_q;
        chunk_start_d = 1'b0;

        if (accept) begin
            wr_sm_d    = in_sparsemap_i;
            wr_data_d  = in_nonzero_data_i;
            wr_valid_d = 1'b1;
            wr_count_d = wr_cnt_q;
            wr_sel_d   = wr_ptr_q;
            if (last_beat) begin
                wr_cnt_d             = '0;
                buf_full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d             = ~wr_ptr_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            R_IDLE: begin
                if (buf_rdy_q[rd_ptr_q]) begin
                    chunk_start_d = 1'b1;
                    state_d       = R_ACTIVE;
                end
            end
            R_ACTIVE: begin
                if (chunk_done_i) begin
                    // The accepting buffer is never full, so this clear cannot
                    // collide with the full-set above.
                    buf_full_d[rd_ptr_q] = 1'b0;
                    buf_rdy_d[rd_ptr_q]  = 1'b0;
                    rd_ptr_d             = ~rd_ptr_q;
                    state_d              = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase

        // Visible to the reader only once the memory has captured the last beat.
        if (wr_valid_q && (wr_count_q == LAST_CNT)) begin
            buf_rdy_d[wr_sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= 1'b0;
            wr_cnt_q      <= '0;
            buf_full_q    <= '0;
            buf_rdy_q     <= '0;
            rd_ptr_q      <= 1'b0;
            state_q       <= R_IDLE;
            wr_sm_q       <= '0;
            wr_data_q     <= '0;
            wr_valid_q    <= 1'b0;
            wr_count_q    <= '0;
            wr_sel_q      <= 1'b0;
            chunk_start_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wr_cnt_q      <= wr_cnt_d;
            buf_full_q    <= buf_full_d;
            buf_rdy_q     <= buf_rdy_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            wr_sm_q       <= wr_sm_d;
            wr_data_q     <= wr_data_d;
            wr_valid_q    <= wr_valid_d;
            wr_count_q    <= wr_count_d;
            wr_sel_q      <= wr_sel_d;
            chunk_start_q <= chunk_start_d;
        end
    end

    assign wr_sparsemap_o    = wr_sm_q;
    assign wr_nonzero_data_o = wr_data_q;
    assign wr_valid_o        = wr_valid_q;
    assign wr_count_o        = wr_count_q;
    assign wr_sel_o          = wr_sel_q;
    assign rd_sel_o          = rd_ptr_q;
    assign chunk_start_o     = chunk_start_q;
    assign chunk_ready_o     = (state_q == R_ACTIVE);

endmodule

// File: tb/tb_data_chunk_loader.sv
// Self-checking bench for data_chunk_loader with MEM_SIZE=64, BUS_SIZE=16.
// Accepted beats are pushed to a scoreboard with the expected beat index and
// buffer; a negedge monitor pops and compares every write strobe.
module tb_data_chunk_loader;

    localparam int unsigned MEM = 64;
    localparam int unsigned BUS = 16;

    typedef struct packed {
        logic [BUS-1:0]      sm;
        logic [BUS-1:0][7:0] data;
        logic [1:0]          cnt;
        logic                sel;
    } wr_exp_t;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [BUS-1:0]      in_sparsemap_i = '0;
    logic [BUS-1:0][7:0] in_nonzero_data_i = '0;
    logic [BUS-1:0]      wr_sparsemap_o;
    logic [BUS-1:0][7:0] wr_nonzero_data_o;
    logic                wr_valid_o;
    logic [1:0]          wr_count_o;
    logic                wr_sel_o;
    logic                rd_sel_o;
    logic                chunk_start_o;
    logic                chunk_ready_o;
    logic                chunk_done_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int n_acc = 0;
    int acc_cnt = 0;
    int beats_left = 0;
    int base;
    logic [BUS-1:0] sm_next = '0;
    wr_exp_t exp_q[$];
    wr_exp_t mon_e;

    data_chunk_loader #(
        .MEM_SIZE(MEM),
        .BUS_SIZE(BUS)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_sparsemap_i   (in_sparsemap_i),
        .in_nonzero_data_i(in_nonzero_data_i),
        .wr_sparsemap_o   (wr_sparsemap_o),
        .wr_nonzero_data_o(wr_nonzero_data_o),
        .wr_valid_o       (wr_valid_o),
        .wr_count_o       (wr_count_o),
        .wr_sel_o         (wr_sel_o),
        .rd_sel_o         (rd_sel_o),
        .chunk_start_o    (chunk_start_o),
        .chunk_ready_o    (chunk_ready_o),
        .chunk_done_i     (chunk_done_i)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write-strobe monitor and chunk_start counter.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (wr_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_val("wr_unexpected", 128'd1, 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("wr_sm", 128'(wr_sparsemap_o), 128'(mon_e.sm));
                    check_val("wr_data", wr_nonzero_data_o, mon_e.data);
                    check_val("wr_count", 128'(wr_count_o), 128'(mon_e.cnt));
                    check_val("wr_sel", 128'(wr_sel_o), 128'(mon_e.sel));
                end
            end
            if (chunk_start_o) starts++;
        end
    end

    task automatic new_beat();
        in_sparsemap_i = sm_next;
        sm_next        = sm_next + 1'b1;
        for (int i = 0; i < int'(BUS); i++) in_nonzero_data_i[i] = 8'($urandom);
        in_valid_i = 1'b1;
    endtask

    task automatic start_stream(input int k, input logic [BUS-1:0] first_sm);
        beats_left = k;
        sm_next    = first_sm;
        new_beat();
    endtask

    // One clock: predict acceptance, push the expected write, then advance.
    task automatic cycle();
        logic    acc;
        wr_exp_t e;
        acc = in_valid_i && in_ready_o && !rst_i;
        if (acc) begin
            e.sm   = in_sparsemap_i;
            e.data = in_nonzero_data_i;
            e.cnt  = n_acc[1:0];
            e.sel  = n_acc[2];
            exp_q.push_back(e);
            n_acc++;
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            beats_left--;
            if (beats_left > 0) new_beat();
            else in_valid_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        in_valid_i   = 1'b0;
        chunk_done_i = 1'b0;
        beats_left   = 0;
        cycle();
        rst_i = 1'b1;
        #1;
        check_val("rst_in_ready", 128'(in_ready_o), 128'd0);
        cycle();
        cycle();
        rst_i = 1'b0;
        n_acc = 0;
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        repeat (3) cycle();
        check_val("rst_in_ready", 128'(in_ready_o), 128'd0);
        check_val("rst_wr_valid", 128'(wr_valid_o), 128'd0);
        check_val("rst_wr_count", 128'(wr_count_o), 128'd0);
        check_val("rst_wr_sel", 128'(wr_sel_o), 128'd0);
        check_val("rst_rd_sel", 128'(rd_sel_o), 128'd0);
        check_val("rst_start", 128'(chunk_start_o), 128'd0);
        check_val("rst_ready", 128'(chunk_ready_o), 128'd0);
        rst_i = 1'b0;
        #1;
        check_val("post_rst_in_ready", 128'(in_ready_o), 128'd1);

        // Single chunk
        start_stream(4, 16'h0001);
        for (int g = 0; g < 40 && beats_left > 0; g++) cycle();
        check_val("t1_all_accepted", 128'(beats_left), 128'd0);
        check_val("t1_start_e0", 128'(chunk_start_o), 128'd0);
        cycle();
        check_val("t1_start_e1", 128'(chunk_start_o), 128'd0);
        check_val("t1_ready_e1", 128'(chunk_ready_o), 128'd0);
        cycle();
        check_val("t1_start_e2", 128'(chunk_start_o), 128'd1);
        check_val("t1_ready_e2", 128'(chunk_ready_o), 128'd1);
        check_val("t1_rd_sel", 128'(rd_sel_o), 128'd0);
        cycle();
        check_val("t1_start_e3", 128'(chunk_start_o), 128'd0);
        check_val("t1_ready_e3", 128'(chunk_ready_o), 128'd1);
        chunk_done_i = 1'b1;
        cycle();
        chunk_done_i = 1'b0;
        check_val("t1_done_ready", 128'(chunk_ready_o), 128'd0);
        check_val("t1_done_rd_sel", 128'(rd_sel_o), 128'd1);

        // Back-pressure: 12 beats offered, only two chunks fit
        do_reset();
        base = acc_cnt;
        start_stream(12, 16'h0100);
        repeat (12) cycle();
        check_val("t2_accepted8", 128'(acc_cnt - base), 128'd8);
        check_val("t2_stalled", 128'(in_ready_o), 128'd0);
        check_val("t2_rd_sel0", 128'(rd_sel_o), 128'd0);
        check_val("t2_active0", 128'(chunk_ready_o), 128'd1);
        chunk_done_i = 1'b1;
        cycle();
        chunk_done_i = 1'b0;
        check_val("t2_rd_sel1", 128'(rd_sel_o), 128'd1);
        check_val("t2_ready_rise", 128'(in_ready_o), 128'd1);
        base = acc_cnt;
        cycle();
        check_val("t2_beat9_taken", 128'(acc_cnt - base), 128'd1);
        check_val("t2_start_b1", 128'(chunk_start_o), 128'd1);

        // Done on the same edge as the last-beat accept into the other buffer
        cycle();
        cycle();
        check_val("t5_one_left", 128'(beats_left), 128'd1);
        chunk_done_i = 1'b1;
        cycle();
        chunk_done_i = 1'b0;
        check_val("t5_last_taken", 128'(beats_left), 128'd0);
        check_val("t5_rd_sel", 128'(rd_sel_o), 128'd0);
        check_val("t5_idle", 128'(chunk_ready_o), 128'd0);
        check_val("t5_in_ready", 128'(in_ready_o), 128'd1);
        cycle();
        check_val("t5_start_early", 128'(chunk_start_o), 128'd0);
        cycle();
        check_val("t5_start", 128'(chunk_start_o), 128'd1);
        check_val("t5_active", 128'(chunk_ready_o), 128'd1);
        check_val("t5_rd_sel_start", 128'(rd_sel_o), 128'd0);

        // Done while idle is ignored
        chunk_done_i = 1'b1;
        cycle();
        chunk_done_i = 1'b0;
        check_val("t4_to_idle", 128'(chunk_ready_o), 128'd0);
        cycle();
        base = starts;
        chunk_done_i = 1'b1;
        cycle();
        cycle();
        chunk_done_i = 1'b0;
        cycle();
        check_val("t4_rd_sel_hold", 128'(rd_sel_o), 128'd1);
        check_val("t4_still_idle", 128'(chunk_ready_o), 128'd0);
        check_val("t4_no_start", 128'(starts - base), 128'd0);
        check_val("t4_in_ready", 128'(in_ready_o), 128'd1);

        // Back-to-back chunks without a bubble
        do_reset();
        base = acc_cnt;
        start_stream(8, 16'h0200);
        repeat (8) cycle();
        check_val("t3_no_bubble", 128'(acc_cnt - base), 128'd8);
        check_val("t3_both_full", 128'(in_ready_o), 128'd0);

        // Reset mid-chunk
        do_reset();
        start_stream(2, 16'h0300);
        cycle();
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        n_acc = 0;
        #1;
        check_val("t6_wr_valid", 128'(wr_valid_o), 128'd0);
        base = starts;
        start_stream(4, 16'h0400);
        repeat (4) cycle();
        cycle();
        check_val("t6_no_stale", 128'(starts - base), 128'd0);
        check_val("t6_start_early", 128'(chunk_start_o), 128'd0);
        cycle();
        check_val("t6_start", 128'(chunk_start_o), 128'd1);
        check_val("t6_rd_sel", 128'(rd_sel_o), 128'd0);

        cycle();
        cycle();
        check_val("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
